// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - issue/writeback handshake bundle for alu_seq
// master = issue stage and writeback consumer, slave = the ALU itself.
interface alu_seq_if #(
  parameter int WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;
  logic             illegal;
  logic             busy;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, flags, illegal, busy
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, flags, illegal, busy
  );
endinterface

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked ALU with shifts, iterative multiply and NZCV flags
// Single-cycle ops load the output register at accept; MUL runs WIDTH shift-add steps.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  alu_seq_if.slave   bus
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] MUL  = 1'b1;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_OR  = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b0110;
  localparam logic [3:0] OP_LSL = 4'b0111;
  localparam logic [3:0] OP_LSR = 4'b1000;
  localparam logic [3:0] OP_ASR = 4'b1001;
  localparam logic [3:0] OP_MUL = 4'b1010;

  logic [0:0]         state;
  logic               out_valid_q;
  logic [WIDTH-1:0]   result_q;
  logic [3:0]         flags_q;
  logic               illegal_q;

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mplier;
  logic [SHW-1:0]     count;

  logic               accept;
  logic               load_alu;
  logic               load_mul;
  logic               mul_last;
  logic [2*WIDTH-1:0] acc_next;

  logic [SHW-1:0]     amt;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [WIDTH:0]     lsl_w;
  logic [WIDTH:0]     lsr_w;
  logic signed [WIDTH:0] asr_in;
  logic signed [WIDTH:0] asr_w;

  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               alu_v;
  logic               alu_ill;

  assign bus.in_ready  = (state == IDLE) && (!out_valid_q || bus.out_ready);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;
  assign bus.illegal   = illegal_q;
  assign bus.busy      = (state == MUL);

  assign accept   = bus.in_valid && bus.in_ready;
  assign load_alu = accept && (bus.op != OP_MUL);
  assign mul_last = (count == SHW'(WIDTH - 1));
  assign load_mul = (state == MUL) && mul_last;
  assign acc_next = mplier[0] ? (acc + mcand) : acc;

  // One extra bit on each shifter captures the last bit shifted out as carry.
  assign amt    = bus.b[SHW-1:0];
  assign sum    = {1'b0, bus.a} + {1'b0, bus.b};
  assign diff   = {1'b0, bus.a} - {1'b0, bus.b};
  assign lsl_w  = {1'b0, bus.a} << amt;
  assign lsr_w  = {bus.a, 1'b0} >> amt;
  assign asr_in = signed'({bus.a, 1'b0});
  assign asr_w  = asr_in >>> amt;

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ill = 1'b0;
    case (bus.op)
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff[WIDTH-1:0];
        alu_c   = diff[WIDTH];
        alu_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_AND: alu_res = bus.a & bus.b;
      OP_OR:  alu_res = bus.a | bus.b;
      OP_XOR: alu_res = bus.a ^ bus.b;
      OP_NOT: alu_res = ~bus.a;
      OP_LSL: begin
        alu_res = lsl_w[WIDTH-1:0];
        alu_c   = lsl_w[WIDTH];
      end
      OP_LSR: begin
        alu_res = lsr_w[WIDTH:1];
        alu_c   = lsr_w[0];
      end
      OP_ASR: begin
        alu_res = asr_w[WIDTH:1];
        alu_c   = asr_w[0];
      end
      OP_MUL: alu_res = '0;
      default: alu_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= 4'b0000;
      illegal_q   <= 1'b0;
      mcand       <= '0;
      acc         <= '0;
      mplier      <= '0;
      count       <= '0;
    end else begin
      if (state == IDLE) begin
        if (accept && (bus.op == OP_MUL)) begin
          mcand  <= {{WIDTH{1'b0}}, bus.a};
          mplier <= bus.b;
          acc    <= '0;
          count  <= '0;
          state  <= MUL;
        end
      end else begin
        acc    <= acc_next;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        count  <= count + 1'b1;
        if (mul_last) begin
          state <= IDLE;
        end
      end

      // Illegal ops leave alu_res at zero, so the generic flag formula yields 0100.
      if (load_alu) begin
        out_valid_q <= 1'b1;
        result_q    <= alu_res;
        flags_q     <= {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};
        illegal_q   <= alu_ill;
      end else if (load_mul) begin
        out_valid_q <= 1'b1;
        result_q    <= acc_next[WIDTH-1:0];
        flags_q     <= {acc_next[WIDTH-1], (acc_next[WIDTH-1:0] == '0),
                        (acc_next[2*WIDTH-1:WIDTH] != '0), 1'b0};
        illegal_q   <= 1'b0;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq
// Table vectors feed a scoreboard; hand sequences cover MUL latency, reset, backpressure.
module tb_alu_seq;
  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  fl;
    logic        ill;
  } vec_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   cyc;
  logic [36:0] sb[$];
  logic [36:0] sb_exp;
  vec_t vecs[$];

  alu_seq_if #(.WIDTH(32)) bus ();
  alu_seq_if #(.WIDTH(8))  bus8 ();

  alu_seq #(.WIDTH(32)) u_dut  (.clk(clk), .rst(rst), .bus(bus));
  alu_seq #(.WIDTH(8))  u_dut8 (.clk(clk), .rst(rst), .bus(bus8));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] res, input logic [3:0] fl, input logic ill);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.res = res; v.fl = fl; v.ill = ill;
    return v;
  endfunction

  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 64'd1, 64'd0);
      end else begin
        sb_exp = sb.pop_front();
        chk("sb_result", {27'd0, bus.result, bus.flags, bus.illegal}, {27'd0, sb_exp});
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input logic [3:0] fl, input logic ill);
    bit got;
    got = 0;
    bus.in_valid = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        sb.push_back({res, fl, ill});
        got = 1;
      end
      @(posedge clk);
      #1;
    end
    if (!got) chk("accept_timeout", 64'd0, 64'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 200 && sb.size() != 0; c++) begin
      @(posedge clk);
      #2;
    end
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int n;
    int c0;
    bit stall_ok;
    total = 0;
    bad = 0;
    cyc = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.op = 4'd0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b1;
    bus8.in_valid = 1'b0; bus8.op = 4'd0; bus8.a = '0; bus8.b = '0; bus8.out_ready = 1'b1;

    vecs.push_back(mk(4'b0001, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1001, 1'b0));
    vecs.push_back(mk(4'b0010, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 4'b1010, 1'b0));
    vecs.push_back(mk(4'b0001, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0110, 1'b0));
    vecs.push_back(mk(4'b0010, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0001, 1'b0));
    vecs.push_back(mk(4'b0011, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b1000, 1'b0));
    vecs.push_back(mk(4'b0100, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 4'b0000, 1'b0));
    vecs.push_back(mk(4'b0101, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h00000000, 4'b0100, 1'b0));
    vecs.push_back(mk(4'b0110, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 4'b1000, 1'b0));
    vecs.push_back(mk(4'b0111, 32'h12345678, 32'h00000000, 32'h12345678, 4'b0000, 1'b0));
    vecs.push_back(mk(4'b0111, 32'h80000001, 32'h00000001, 32'h00000002, 4'b0010, 1'b0));
    vecs.push_back(mk(4'b1000, 32'h00000003, 32'd33,       32'h00000001, 4'b0010, 1'b0));
    vecs.push_back(mk(4'b1001, 32'h80000001, 32'h00000001, 32'hC0000000, 4'b1010, 1'b0));
    vecs.push_back(mk(4'b1001, 32'h80000000, 32'd31,       32'hFFFFFFFF, 4'b1000, 1'b0));
    vecs.push_back(mk(4'b1000, 32'h80000000, 32'd31,       32'h00000001, 4'b0000, 1'b0));
    vecs.push_back(mk(4'b1010, 32'd7,        32'd6,        32'd42,       4'b0000, 1'b0));
    vecs.push_back(mk(4'b1010, 32'h00010000, 32'h00010000, 32'h00000000, 4'b0110, 1'b0));
    vecs.push_back(mk(4'b1010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 4'b0010, 1'b0));
    vecs.push_back(mk(4'b1111, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 4'b0100, 1'b1));
    vecs.push_back(mk(4'b0000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 4'b0100, 1'b1));

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_result_flags", {28'd0, bus.result, bus.flags}, 64'd0);
    chk("rst_illegal", 64'(bus.illegal), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;

    foreach (vecs[i]) issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].fl, vecs[i].ill);
    drain();

    // ADD latency and back-to-back throughput
    c0 = cyc;
    issue(4'b0001, 32'h7FFFFFFF, 32'h1, 32'h80000000, 4'b1001, 1'b0);
    issue(4'b0001, 32'd1, 32'd2, 32'd3, 4'b0000, 1'b0);
    issue(4'b0001, 32'h10, 32'h20, 32'h30, 4'b0000, 1'b0);
    issue(4'b0001, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFF, 4'b1000, 1'b0);
    chk("throughput_cycles", 64'(cyc - c0), 64'd4);
    drain();
    issue(4'b0001, 32'h7FFFFFFF, 32'h1, 32'h80000000, 4'b1001, 1'b0);
    @(negedge clk);
    chk("add_latency_valid", 64'(bus.out_valid), 64'd1);
    drain();

    // backpressure: XOR result held, then drain + accept AND on the same edge
    bus.out_ready = 1'b0;
    issue(4'b0101, 32'hFF00FF00, 32'h0F0F0F0F, 32'hF00FF00F, 4'b1000, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("bp_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_hold", {28'd0, bus.result, bus.flags}, {28'd0, 32'hF00FF00F, 4'b1000});
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    issue(4'b0011, 32'hFFFF0000, 32'h12345678, 32'h12340000, 4'b0000, 1'b0);
    @(negedge clk);
    chk("bp_new_result", {27'd0, bus.out_valid, bus.result}, {27'd0, 1'b1, 32'h12340000});
    drain();

    // reset in cycle 5 of a MUL discards it
    issue(4'b1010, 32'd7, 32'd6, 32'd42, 4'b0000, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("mid_mul_busy", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    #1;
    void'(sb.pop_back());
    chk("mid_rst_valid_busy", {62'd0, bus.out_valid, bus.busy}, 64'd0);
    chk("mid_rst_result_flags", {28'd0, bus.result, bus.flags}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;

    // MUL latency: exactly WIDTH edges, in_ready low meanwhile
    issue(4'b1010, 32'h00010000, 32'h00010000, 32'h00000000, 4'b0110, 1'b0);
    n = 0;
    stall_ok = 1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus.out_valid) break;
      if (bus.in_ready || !bus.busy) stall_ok = 0;
      n++;
    end
    chk("mul_latency", 64'(n), 64'd32);
    chk("mul_stall", 64'(stall_ok), 64'd1);
    chk("mul_busy_done", 64'(bus.busy), 64'd0);
    drain();

    // WIDTH=8 instance
    @(posedge clk);
    #1;
    bus8.in_valid = 1'b1; bus8.op = 4'b0001; bus8.a = 8'h7F; bus8.b = 8'h01;
    @(negedge clk);
    chk("w8_in_ready", 64'(bus8.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus8.in_valid = 1'b0;
    @(negedge clk);
    chk("w8_add", {51'd0, bus8.out_valid, bus8.result, bus8.flags}, {51'd0, 1'b1, 8'h80, 4'b1001});
    @(posedge clk);
    #1;
    bus8.in_valid = 1'b1; bus8.op = 4'b1010; bus8.a = 8'h10; bus8.b = 8'h10;
    @(posedge clk);
    #1;
    bus8.in_valid = 1'b0;
    n = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus8.out_valid) break;
      n++;
    end
    chk("w8_mul_latency", 64'(n), 64'd8);
    chk("w8_mul", {52'd0, bus8.result, bus8.flags}, {52'd0, 8'h00, 4'b0110});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the team's combinational ALU. It keeps the existing 3-bit operation encodings and adds shifts, an iterative multiply, NZCV flags and an illegal-opcode indication. Results are held in a one-entry output register, so the block sits between the decode/issue stage and the writeback stage of the SCC datapath. Single-cycle operations complete in one cycle; multiply takes WIDTH cycles.

## Interface
- WIDTH, 32, operand/result width (≥4, power of two)
- SHW, $clog2(WIDTH), shift-amount width (derived, not overridden)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operation offered
- in_ready  out  1  block accepts operation this cycle
- op  in  4  operation code
- a  in  WIDTH  operand 1
- b  in  WIDTH  operand 2 / shift amount in b[SHW-1:0]
- out_valid  out  1  result register holds a result
- out_ready  in  1  consumer takes result this cycle
- result  out  WIDTH  registered result
- flags  out  4  {N,Z,C,V}, registered with result
- illegal  out  1  registered; result came from an unknown opcode
- busy  out  1  high while in state MUL

## Operation
- Encodings: 0001 ADD, 0010 SUB, 0011 AND, 0100 OR, 0101 XOR, 0110 NOT(a), 0111 LSL, 1000 LSR, 1001 ASR, 1010 MUL. Any other code is illegal: result=0, flags=0100, illegal=1.
- Acceptance occurs when in_valid && in_ready at a rising edge.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- FSM states:
  - IDLE: a non-MUL op computes combinationally and loads the output register at the accept edge. MUL loads the multiplicand, multiplier and accumulator, clears count and goes to MUL.
  - MUL: one shift-add step per cycle over the unsigned operands. On the WIDTH-th step, load the output register and return to IDLE.
- Flags:
  - N = result[WIDTH-1].
  - Z = (result==0).
  - ADD: C = carry out; V = signed overflow.
  - SUB: C = borrow (a<b unsigned); V = signed overflow.
  - LSL/LSR/ASR: C = last bit shifted out; C=0 when amount is 0; V=0.
  - MUL: result = low WIDTH bits of the product; C = 1 if the high WIDTH bits are nonzero; V=0.
  - Logic ops: C=V=0.
- ASR replicates a[WIDTH-1]. Shift amount is b mod WIDTH.
- Output register holds result, flags and illegal stable while out_valid && !out_ready. out_valid clears at an edge with out_ready, unless a new accept reloads it at that same edge.
- rst (any time, including mid-MUL): state=IDLE and the in-flight operation is discarded. out_valid=0, result=0, flags=0000, illegal=0, busy=0, internal counters=0.

## Timing
- Non-MUL accepted at edge t: out_valid=1 after edge t.
- MUL accepted at edge t: busy=1 after t; result loaded at edge t+WIDTH; out_valid=1 and busy=0 after t+WIDTH.
- Throughput: one non-MUL op per cycle when out_ready is held high (drain and reload at the same edge).
- in_ready is 0 throughout MUL, and while out_valid && !out_ready.
- in_ready is combinational from state, out_valid and out_ready. There is no combinational path from a/b/op to any output.

## Test plan
- Reset asserted mid-MUL (cycle 5 of 32) → immediately out_valid=0, busy=0, result=0, flags=0000. After release, in_ready=1 with out_ready=1.
- ADD a=0x7FFFFFFF, b=1 → result 0x80000000, flags N=1 Z=0 C=0 V=1, out_valid one cycle after accept. SUB a=0, b=1 → result 0xFFFFFFFF, flags 1010.
- MUL a=0x00010000, b=0x00010000 (WIDTH=32) → result 0, flags 0110, out_valid exactly 32 edges after accept, in_ready=0 meanwhile. MUL 7×6 → 42, flags 0000.
- ASR a=0x80000001, b=1 → result 0xC0000000, C=1. LSL b=0 → result=a, C=0. LSR b=33 behaves as shift by 1.
- Backpressure: out_ready=0 for 3 cycles after an XOR result → result/flags stable, in_ready=0. Raise out_ready with a new AND offered → drain and accept at the same edge, new result next cycle.
- op=1111 → illegal=1, result=0, flags 0100. Back-to-back ADDs with out_ready=1 → one result per cycle. Repeat the ADD check with WIDTH=8.
